// File: rtl/dso_trig_gen_pkg.sv
// Shared encodings for the DSO trigger generator.
// Mode, FSM state and slope constants plus small mode helpers.
package dso_pkg;

  typedef logic [1:0] trig_mode_t;
  typedef logic [1:0] trig_state_t;

  localparam trig_mode_t TM_NORMAL = 2'b00;
  localparam trig_mode_t TM_AUTO   = 2'b01;
  localparam trig_mode_t TM_SINGLE = 2'b10;

  localparam trig_state_t ST_IDLE    = 2'b00;
  localparam trig_state_t ST_SEEK    = 2'b01;
  localparam trig_state_t ST_HOLDOFF = 2'b10;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  function automatic logic is_auto(
    input trig_mode_t m
  );
    return m == TM_AUTO;
  endfunction

  function automatic logic is_single(
    input trig_mode_t m
  );
    return m == TM_SINGLE;
  endfunction

endpackage

// File: rtl/dso_trig_gen_if.sv
// Sample, config and trigger-output bundle of the trigger generator.
// master drives samples/config, slave is the trigger block.
interface dso_trig_gen_if #(
  parameter int DW     = 8,
  parameter int HOLD_W = 16
);

  logic [DW-1:0]     adc_data;
  logic [DW-1:0]     trig_level;
  logic [DW-1:0]     trig_hyst;
  logic              trig_slope;
  logic [1:0]        trig_mode;
  logic [HOLD_W-1:0] holdoff;
  logic              arm;
  logic              disarm;
  logic              trig_out;
  logic              auto_fired;
  logic              armed;
  logic [15:0]       trig_cnt;

  modport master (
    output adc_data, trig_level, trig_hyst,
    output trig_slope, trig_mode, holdoff,
    output arm, disarm,
    input  trig_out, auto_fired, armed, trig_cnt
  );

  modport slave (
    input  adc_data, trig_level, trig_hyst,
    input  trig_slope, trig_mode, holdoff,
    input  arm, disarm,
    output trig_out, auto_fired, armed, trig_cnt
  );

endinterface

// File: rtl/dso_trig_gen_cmp.sv
// Sample register and level/hysteresis comparator.
// pre_o arms the edge, fire_o completes it once the level is crossed.
module dso_trig_cmp
  import dso_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_cnt,
  input  logic          rst,
  input  logic [DW-1:0] sample_i,
  input  logic [DW-1:0] level_i,
  input  logic [DW-1:0] hyst_i,
  input  logic          slope_i,
  input  logic          pre_q_i,
  output logic          pre_o,
  output logic          fire_o
);

  logic [DW-1:0] s_q;

  always_ff @(posedge clk_cnt) begin
    if (rst) s_q <= '0;
    else     s_q <= sample_i;
  end

  // One extra bit keeps the differences from wrapping.
  logic [DW:0] s_x;
  logic [DW:0] l_x;
  logic [DW:0] h_x;
  logic [DW:0] d_rise;
  logic [DW:0] d_fall;
  logic        pre_rise;
  logic        pre_fall;

  assign s_x    = {1'b0, s_q};
  assign l_x    = {1'b0, level_i};
  assign h_x    = {1'b0, hyst_i};
  assign d_rise = l_x - s_x;
  assign d_fall = s_x - l_x;

  assign pre_rise = (s_x < l_x) && (d_rise >= h_x);
  assign pre_fall = (s_x > l_x) && (d_fall >= h_x);

  assign pre_o = (slope_i == SLOPE_FALL) ? pre_fall
                                         : pre_rise;

  assign fire_o = pre_q_i &&
    ((slope_i == SLOPE_FALL) ? (s_x <= l_x)
                             : (s_x >= l_x));

endmodule

// File: rtl/dso_trig_gen.sv
// DSO trigger generator: config latch, SEEK/HOLDOFF FSM,
// auto timeout and trigger counter on the sample clock.
module dso_trig_gen
  import dso_pkg::*;
#(
  parameter int DW           = 8,
  parameter int HOLD_W       = 16,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic          clk_cnt,
  input  logic          rst,
  dso_trig_gen_if.slave bus
);

  localparam int TW =
    (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(AUTO_TIMEOUT - 1);

  trig_state_t       state_q, state_d;
  logic              pre_q, pre_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              trig_q, trig_d;
  logic              auto_q, auto_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DW-1:0]     lvl_q, lvl_d;
  logic [DW-1:0]     hyst_q, hyst_d;
  logic              slope_q, slope_d;
  trig_mode_t        mode_q, mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic pre;
  logic fire;
  logic tmo;

  dso_trig_cmp #(
    .DW (DW)
  ) u_cmp (
    .clk_cnt  (clk_cnt),
    .rst      (rst),
    .sample_i (bus.adc_data),
    .level_i  (lvl_q),
    .hyst_i   (hyst_q),
    .slope_i  (slope_q),
    .pre_q_i  (pre_q),
    .pre_o    (pre),
    .fire_o   (fire)
  );

  assign tmo = (tcnt_q == TMAX);

  logic st_idle;
  logic st_seek;
  logic st_hold;

  assign st_idle = !bus.disarm && (state_q == ST_IDLE);
  assign st_seek = !bus.disarm && (state_q == ST_SEEK);
  assign st_hold = !bus.disarm && (state_q == ST_HOLDOFF);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    trig_d  = 1'b0;
    auto_d  = 1'b0;
    lvl_d   = lvl_q;
    hyst_d  = hyst_q;
    slope_d = slope_q;
    mode_d  = mode_q;
    hold_d  = hold_q;

    unique case (1'b1)
      st_idle: begin
        if (bus.arm) begin
          lvl_d   = bus.trig_level;
          hyst_d  = bus.trig_hyst;
          slope_d = bus.trig_slope;
          mode_d  = bus.trig_mode;
          hold_d  = bus.holdoff;
          pre_d   = 1'b0;
          tcnt_d  = '0;
          state_d = ST_SEEK;
        end
      end
      st_seek: begin
        if (fire || (is_auto(mode_q) && tmo)) begin
          trig_d = 1'b1;
          // A level crossing wins over a simultaneous timeout.
          auto_d = !fire;
          pre_d  = 1'b0;
          if (is_single(mode_q)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hcnt_d  = hold_q;
          end
        end else begin
          if (pre) pre_d = 1'b1;
          if (!tmo) tcnt_d = tcnt_q + 1'b1;
        end
      end
      st_hold: begin
        if (hcnt_q == '0) begin
          state_d = ST_SEEK;
          pre_d   = 1'b0;
          tcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_d = cnt_q + {15'd0, trig_d};
  end

  always_ff @(posedge clk_cnt) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= 1'b0;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      trig_q  <= 1'b0;
      auto_q  <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      hyst_q  <= '0;
      slope_q <= SLOPE_RISE;
      mode_q  <= TM_NORMAL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
      trig_q  <= trig_d;
      auto_q  <= auto_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      hyst_q  <= hyst_d;
      slope_q <= slope_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.trig_out   = trig_q;
  assign bus.auto_fired = auto_q;
  assign bus.armed      = (state_q == ST_SEEK);
  assign bus.trig_cnt   = cnt_q;

endmodule

// File: tb/tb_dso_trig_gen.sv
// Directed bench for dso_trig_gen.
// Hand-computed vectors, checked one cycle at a time.
module tb_dso_trig_gen;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dso_trig_gen_if #(.DW(8), .HOLD_W(16)) bus ();

  dso_trig_gen #(
    .DW           (8),
    .HOLD_W       (16),
    .AUTO_TIMEOUT (16)
  ) dut (
    .clk_cnt (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk4(
    input string tag,
    input logic  t,
    input logic  a,
    input logic  arm_e,
    input int    c
  );
    chk({tag, "_trig"}, 32'(bus.trig_out), 32'(t));
    chk({tag, "_auto"}, 32'(bus.auto_fired), 32'(a));
    chk({tag, "_armed"}, 32'(bus.armed), 32'(arm_e));
    chk({tag, "_cnt"}, 32'(bus.trig_cnt), 32'(c));
  endtask

  task automatic cfg(
    input logic [7:0]  lvl,
    input logic [7:0]  hy,
    input logic        sl,
    input logic [1:0]  md,
    input logic [15:0] ho
  );
    bus.trig_level = lvl;
    bus.trig_hyst  = hy;
    bus.trig_slope = sl;
    bus.trig_mode  = md;
    bus.holdoff    = ho;
  endtask

  initial begin
    rst          = 1'b1;
    bus.adc_data = 8'd0;
    bus.arm      = 1'b0;
    bus.disarm   = 1'b0;
    cfg(8'd128, 8'd8, 1'b0, 2'b00, 16'd3);
    ticks(2);
    chk4("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("idle_armed", 32'(bus.armed), 0);

    // rising edge, normal, holdoff 3
    bus.adc_data = 8'd100;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.trig_level = 8'd255;
    chk("t1_armed", 32'(bus.armed), 1);
    bus.adc_data = 8'd100; tick();
    bus.adc_data = 8'd125; tick();
    bus.adc_data = 8'd130; tick();
    chk("t1_early", 32'(bus.trig_out), 0);
    tick();
    chk4("t1_fire", 1, 0, 0, 1);
    tick();
    chk("t1_pulse", 32'(bus.trig_out), 0);
    ticks(2);
    chk("t1_hold", 32'(bus.armed), 0);
    tick();
    chk("t1_reseek", 32'(bus.armed), 1);

    // hysteresis noise rejection
    bus.adc_data = 8'd125; tick();
    chk("t2_n0", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd130; tick();
    chk("t2_n1", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd125; tick();
    chk("t2_n2", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd131; tick();
    chk("t2_n3", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd119; tick();
    chk("t2_n4", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd135; tick();
    chk("t2_n5", 32'(bus.trig_out), 0);
    tick();
    chk4("t2_fire", 1, 0, 0, 2);

    // disarm in HOLDOFF keeps the count
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;
    chk4("dis_hold", 0, 0, 0, 2);
    ticks(5);
    chk("dis_stay", 32'(bus.armed), 0);

    // falling slope, holdoff 0
    cfg(8'd50, 8'd4, 1'b1, 2'b00, 16'd0);
    bus.adc_data = 8'd50;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.adc_data = 8'd60; tick();
    bus.adc_data = 8'd49; tick();
    chk("t3_early", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd52; tick();
    chk4("t3_fire", 1, 0, 0, 3);
    tick();
    chk4("t3_ho0", 0, 0, 1, 3);
    bus.adc_data = 8'd49; tick();
    chk("t3_nf0", 32'(bus.trig_out), 0);
    bus.adc_data = 8'd45; tick();
    chk("t3_nf1", 32'(bus.trig_out), 0);
    ticks(2);
    chk("t3_nf2", 32'(bus.trig_out), 0);
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;

    // auto timeout 16, holdoff 2
    cfg(8'd200, 8'd8, 1'b0, 2'b01, 16'd2);
    bus.adc_data = 8'd10;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    ticks(15);
    chk4("t4_s16", 0, 0, 1, 3);
    tick();
    chk4("t4_auto1", 1, 1, 0, 4);
    ticks(18);
    chk("t4_gap", 32'(bus.trig_out), 0);
    tick();
    chk4("t4_auto2", 1, 1, 0, 5);
    ticks(17);
    bus.adc_data = 8'd210;
    tick();
    tick();
    chk4("t4_tie", 1, 0, 0, 6);
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;

    // single mode and rearm
    cfg(8'd128, 8'd8, 1'b0, 2'b10, 16'd5);
    bus.adc_data = 8'd100;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    tick();
    bus.adc_data = 8'd140; tick();
    tick();
    chk4("t5_fire", 1, 0, 0, 7);
    tick();
    chk4("t5_idle", 0, 0, 0, 7);
    bus.adc_data = 8'd100; ticks(2);
    bus.adc_data = 8'd140; ticks(3);
    chk4("t5_quiet", 0, 0, 0, 7);
    bus.adc_data = 8'd100;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("t5_rearm", 32'(bus.armed), 1);
    tick();
    bus.adc_data = 8'd140; tick();
    tick();
    chk4("t5_refire", 1, 0, 0, 8);

    // reset mid SEEK with a pending crossing
    cfg(8'd128, 8'd8, 1'b0, 2'b00, 16'd0);
    bus.adc_data = 8'd100;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    ticks(2);
    rst = 1'b1;
    bus.adc_data = 8'd140;
    tick();
    chk4("t6_rst", 0, 0, 0, 0);
    rst = 1'b0;
    ticks(2);
    chk4("t6_after", 0, 0, 0, 0);

    // disarm beats arm
    bus.arm = 1'b1;
    bus.disarm = 1'b1;
    tick();
    chk("t7_dis_arm", 32'(bus.armed), 0);
    bus.disarm = 1'b0;

    // disarm suppresses a pending fire
    tick();
    bus.arm = 1'b0;
    chk("t8_armed", 32'(bus.armed), 1);
    bus.adc_data = 8'd100; tick();
    bus.adc_data = 8'd140; tick();
    bus.disarm = 1'b1;
    tick();
    bus.disarm = 1'b0;
    chk4("t8_supp", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
